// File: rtl/nibble_load_pkg.sv
// nibble_load_pkg: shared state encoding and default frame width
package nibble_load_pkg;
  localparam int WIDTH_DEF = 4;
  typedef enum logic [1:0] {COLLECT, PARITY, LOAD} state_t;
endpackage

// File: rtl/nibble_shifter.sv
// nibble_shifter: payload shift register, bit counter and running even parity
module nibble_shifter
  import nibble_load_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   shift_en,
  input  logic                   clr,
  input  logic                   in_bit,
  output logic [WIDTH-1:0]       sr_nxt,
  output logic [$clog2(WIDTH):0] bit_cnt,
  output logic                   par
);
  localparam int CW = $clog2(WIDTH) + 1;
  logic [WIDTH-1:0] sr;
  for (genvar i = 0; i < WIDTH; i++) begin : g_sr
    assign sr_nxt[i] = (shift_en && bit_cnt == CW'(i)) ? in_bit : sr[i];
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sr      <= '0;
      bit_cnt <= '0;
      par     <= 1'b0;
    end else begin
      sr      <= sr_nxt;
      bit_cnt <= clr ? '0 : shift_en ? bit_cnt + 1'b1 : bit_cnt;
      par     <= clr ? 1'b0 : shift_en ? par ^ in_bit : par;
    end
  end
endmodule

// File: rtl/nibble_load_ctrl.sv
// nibble_load_ctrl: serial frame receiver that pulses a load enable for a downstream register
module nibble_load_ctrl
  import nibble_load_pkg::*;
#(
  parameter int WIDTH     = WIDTH_DEF,
  parameter bit PARITY_EN = 1'b1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  input  logic             in_bit,
  output logic             in_ready,
  input  logic             abort,
  output logic             load_en,
  output logic [WIDTH-1:0] data_out,
  output logic             par_err,
  output logic             busy
);
  localparam int CW = $clog2(WIDTH) + 1;
  state_t           state, nxt;
  logic             accept, last, shift_en, clr, perr_d, par;
  logic [WIDTH-1:0] sr_nxt;
  logic [CW-1:0]    bit_cnt;
  nibble_shifter #(.WIDTH(WIDTH)) u_shifter (
    .clk      (clk),
    .reset    (reset),
    .shift_en (shift_en),
    .clr      (clr),
    .in_bit   (in_bit),
    .sr_nxt   (sr_nxt),
    .bit_cnt  (bit_cnt),
    .par      (par)
  );
  assign accept   = in_valid && in_ready && !abort;
  assign last     = bit_cnt == CW'(WIDTH - 1);
  assign load_en  = state == LOAD;
  assign in_ready = state != LOAD;
  assign busy     = bit_cnt != '0 || state == PARITY;
  always_comb begin
    nxt      = state;
    shift_en = 1'b0;
    clr      = abort;
    perr_d   = 1'b0;
    if (state == COLLECT && accept) begin
      shift_en = 1'b1;
      clr      = last && !PARITY_EN;
      nxt      = !last ? COLLECT : PARITY_EN ? PARITY : LOAD;
    end else if (state == PARITY && accept) begin
      clr      = 1'b1;
      perr_d   = in_bit != par;
      nxt      = perr_d ? COLLECT : LOAD;
    end else if (state == LOAD) begin
      nxt      = COLLECT;
    end
    if (abort) nxt = COLLECT;
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= COLLECT;
      data_out <= '0;
      par_err  <= 1'b0;
    end else begin
      state    <= nxt;
      par_err  <= perr_d;
      if (nxt == LOAD) data_out <= sr_nxt;
    end
  end
endmodule

// File: tb/tb_nibble_load_ctrl.sv
// tb_nibble_load_ctrl: table-driven directed checks of the nibble load controller
module tb_nibble_load_ctrl;
  logic       clk = 1'b0, reset = 1'b0, in_valid = 1'b0, in_bit = 1'b0, abort = 1'b0;
  logic       in_ready, load_en, par_err, busy;
  logic [3:0] data_out;
  int         n_chk = 0, n_pass = 0;
  typedef struct {
    logic v, b, a, ld, pe, bz, rd;
    logic [3:0] d;
  } vec_t;
  vec_t tv[$];
  always #5 clk = ~clk;
  nibble_load_ctrl #(.WIDTH(4), .PARITY_EN(1'b1)) dut (
    .clk      (clk),
    .reset    (reset),
    .in_valid (in_valid),
    .in_bit   (in_bit),
    .in_ready (in_ready),
    .abort    (abort),
    .load_en  (load_en),
    .data_out (data_out),
    .par_err  (par_err),
    .busy     (busy)
  );
  task automatic chk(input string nm, input logic [3:0] act, input logic [3:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %b expected %b at %0t", nm, act, exp, $time);
  endtask
  task automatic add(input logic v, b, a, ld, pe, bz, rd, input logic [3:0] d);
    tv.push_back('{v, b, a, ld, pe, bz, rd, d});
  endtask
  task automatic add_frame(input logic [3:0] w, input logic p, input logic ok, input logic [3:0] prev);
    for (int i = 0; i < 4; i++) add(1, w[i], 0, 0, 0, 1, 1, prev);
    add(1, p, 0, ok, !ok, 0, !ok, ok ? w : prev);
    add(0, 0, 0, 0, 0, 0, 1, ok ? w : prev);
  endtask
  task automatic run_table();
    foreach (tv[i]) begin
      in_valid = tv[i].v;
      in_bit   = tv[i].b;
      abort    = tv[i].a;
      @(posedge clk);
      #1;
      chk($sformatf("v%0d load_en", i), 4'(load_en), 4'(tv[i].ld));
      chk($sformatf("v%0d par_err", i), 4'(par_err), 4'(tv[i].pe));
      chk($sformatf("v%0d busy", i), 4'(busy), 4'(tv[i].bz));
      chk($sformatf("v%0d in_ready", i), 4'(in_ready), 4'(tv[i].rd));
      chk($sformatf("v%0d data_out", i), data_out, tv[i].d);
    end
    tv.delete();
    in_valid = 1'b0;
    in_bit   = 1'b0;
    abort    = 1'b0;
  endtask
  initial begin
    logic [3:0] w;
    #2;
    chk("rst data_out", data_out, 4'h0);
    chk("rst load_en", 4'(load_en), 4'h0);
    chk("rst par_err", 4'(par_err), 4'h0);
    chk("rst busy", 4'(busy), 4'h0);
    chk("rst in_ready", 4'(in_ready), 4'h1);
    @(posedge clk);
    #1 reset = 1'b1;
    add_frame(4'b1101, 1'b1, 1'b1, 4'h0);
    add_frame(4'b1010, 1'b1, 1'b0, 4'b1101);
    w = 4'b1010;
    for (int i = 0; i < 4; i++) begin
      add(1, w[i], 0, 0, 0, 1, 1, 4'b1101);
      for (int j = 0; j < 3; j++) add(0, 0, 0, 0, 0, 1, 1, 4'b1101);
    end
    add(1, 0, 0, 1, 0, 0, 0, 4'b1010);
    add(0, 0, 0, 0, 0, 0, 1, 4'b1010);
    w = 4'b0011;
    for (int i = 0; i < 4; i++) add(1, w[i], 0, 0, 0, 1, 1, 4'b1010);
    add(1, 0, 0, 1, 0, 0, 0, 4'b0011);
    add(1, 0, 0, 0, 0, 0, 1, 4'b0011);
    w = 4'b1110;
    for (int i = 0; i < 4; i++) add(1, w[i], 0, 0, 0, 1, 1, 4'b0011);
    add(1, 1, 0, 1, 0, 0, 0, 4'b1110);
    add(0, 0, 0, 0, 0, 0, 1, 4'b1110);
    add(1, 1, 0, 0, 0, 1, 1, 4'b1110);
    add(1, 0, 0, 0, 0, 1, 1, 4'b1110);
    add(1, 1, 1, 0, 0, 0, 1, 4'b1110);
    add(0, 0, 0, 0, 0, 0, 1, 4'b1110);
    add_frame(4'b1001, 1'b0, 1'b1, 4'b1110);
    add(1, 1, 0, 0, 0, 1, 1, 4'b1001);
    add(1, 0, 0, 0, 0, 1, 1, 4'b1001);
    run_table();
    reset = 1'b0;
    #1;
    chk("mid rst data_out", data_out, 4'h0);
    chk("mid rst busy", 4'(busy), 4'h0);
    chk("mid rst in_ready", 4'(in_ready), 4'h1);
    chk("mid rst load_en", 4'(load_en), 4'h0);
    @(posedge clk);
    #1;
    chk("held rst data_out", data_out, 4'h0);
    chk("held rst busy", 4'(busy), 4'h0);
    reset = 1'b1;
    add_frame(4'b0111, 1'b1, 1'b1, 4'h0);
    run_table();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
